div_ratio_meter: RTL

DIV_RATIO_METER -- requirements
Module: div_ratio_meter

---
 rtl/div_ratio_meter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/div_ratio_meter.sv
// Measures the period and high time of a divided clock (sig_in) in clk_in cycles.
// Optional DIV_METER_AVG4_EN averages four back-to-back periods.
module div_ratio_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'd65535
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             error,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out
);

  localparam int unsigned      WAIT_W    = 32;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              rise_c, fall_c, timeout_c;
  logic [CNT_W-1:0]  period_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic [WAIT_W-1:0] wait_cnt;

`ifdef DIV_METER_AVG4_EN
  localparam int unsigned ACC_W = CNT_W + 2;
  logic [ACC_W-1:0] acc_period;
  logic [ACC_W-1:0] acc_high;
  logic [1:0]       per_idx;
  logic [ACC_W-1:0] sum_period_c;
  logic [ACC_W-1:0] sum_high_c;

  assign sum_period_c = acc_period + ACC_W'(period_cnt);
  assign sum_high_c   = acc_high + ACC_W'(high_cnt);
`endif

  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

  // Wait counter reaching its last value ends the current measuring state on this cycle.
  assign timeout_c = (wait_cnt >= WAIT_LAST);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
`ifdef DIV_METER_AVG4_EN
      acc_period <= '0;
      acc_high   <= '0;
      per_idx    <= '0;
`endif
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      if (rise_c || fall_c) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          if (timeout_c) begin
            state      <= DONE;
            valid      <= 1'b1;
            error      <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
          end else if (rise_c) begin
            state      <= HIGH;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
`ifdef DIV_METER_AVG4_EN
            acc_period <= '0;
            acc_high   <= '0;
            per_idx    <= '0;
`endif
          end
        end

        // High time freezes on the fall cycle; the period keeps counting.
        HIGH: begin
          if (timeout_c) begin
            state      <= DONE;
            valid      <= 1'b1;
            error      <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
          end else begin
            period_cnt <= sat_inc(period_cnt);
            if (fall_c) begin
              state <= LOW;
            end else begin
              high_cnt <= sat_inc(high_cnt);
            end
          end
        end

        LOW: begin
          if (timeout_c) begin
            state      <= DONE;
            valid      <= 1'b1;
            error      <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
          end else if (rise_c) begin
`ifdef DIV_METER_AVG4_EN
            if (per_idx == 2'd3) begin
              state      <= DONE;
              valid      <= 1'b1;
              error      <= 1'b0;
              period_out <= sum_period_c[ACC_W-1:2];
              high_out   <= sum_high_c[ACC_W-1:2];
            end else begin
              state      <= HIGH;
              acc_period <= sum_period_c;
              acc_high   <= sum_high_c;
              per_idx    <= per_idx + 2'd1;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end
`else
            state      <= DONE;
            valid      <= 1'b1;
            error      <= 1'b0;
            period_out <= period_cnt;
            high_out   <= high_cnt;
`endif
          end else begin
            period_cnt <= sat_inc(period_cnt);
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wait_cnt <= '0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
